// File: rtl/pipe_pkg.sv
// Shared types and constants for the branch resolution slice.
package pipe_pkg;

    localparam int BR_PC_W      = 32;
    localparam int FALLTHRU_OFF = 4;

    typedef enum logic {
        RS_IDLE     = 1'b0,
        RS_REDIRECT = 1'b1
    } rs_state_t;

    // pc/target are carried at BR_PC_W; the top narrows or widens to PC_W.
    typedef struct packed {
        logic               branch;
        logic               pred;
        logic [BR_PC_W-1:0] pc;
        logic [BR_PC_W-1:0] target;
        logic               actual;
    } br_info_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// Carries branch predictions through E/M, resolves in M, and drives the
// predictor update, pipeline flush and fetch redirect handshake.
module branch_resolve
    import pipe_pkg::*;
#(
    parameter int PC_W         = 32,
    parameter int CNT_W        = 32,
    parameter int FALLTHRU_OFF = pipe_pkg::FALLTHRU_OFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branchD,
    input  logic             pred_takeD,
    input  logic [PC_W-1:0]  pcD,
    input  logic [PC_W-1:0]  targetD,
    input  logic             stallE,
    input  logic             flushE,
    input  logic             stallM,
    input  logic             flushM,
    input  logic             actual_takeE,
    output logic             branchM,
    output logic             actual_takeM,
    output logic             errorM,
    output logic             flush_req,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    input  logic             redirect_ready,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    br_info_t  regE;
    br_info_t  regM;
    br_info_t  nextM;
    logic      firstM;
    logic      resolveM;
    logic      loadPc;
    logic [PC_W-1:0] correctPc;
    rs_state_t state;
    rs_state_t nextState;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regE <= '0;
        end else if (flushE) begin
            regE <= '0;
        end else if (!stallE) begin
            regE.branch <= branchD;
            regE.pred   <= pred_takeD;
            regE.pc     <= BR_PC_W'(pcD);
            regE.target <= BR_PC_W'(targetD);
            regE.actual <= 1'b0;
        end
    end

    always_comb begin
        nextM        = regE;
        nextM.actual = actual_takeE;
    end

    // firstM drops after one stalled cycle so a held branch resolves once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regM   <= '0;
            firstM <= 1'b0;
        end else if (flushM) begin
            regM   <= '0;
            firstM <= 1'b1;
        end else if (!stallM) begin
            regM   <= nextM;
            firstM <= 1'b1;
        end else begin
            firstM <= 1'b0;
        end
    end

    assign branchM      = regM.branch;
    assign actual_takeM = regM.actual;
    assign resolveM     = regM.branch & firstM;
    assign errorM       = resolveM & (regM.pred != regM.actual);
    assign correctPc    = regM.actual ? PC_W'(regM.target)
                                      : PC_W'(regM.pc) + PC_W'(FALLTHRU_OFF);

    sat_counter #(.CNT_W(CNT_W)) uBranchCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (resolveM),
        .count (branch_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) uMispredCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (errorM),
        .count (mispred_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RS_IDLE;
            redirect_pc <= '0;
        end else begin
            state <= nextState;
            if (loadPc) begin
                redirect_pc <= correctPc;
            end
        end
    end

    // A fresh mispredict always wins over a pending or completing redirect.
    always_comb begin
        nextState = state;
        flush_req = 1'b0;
        loadPc    = 1'b0;
        case (state)
            RS_IDLE: begin
                if (errorM) begin
                    flush_req = 1'b1;
                    loadPc    = 1'b1;
                    nextState = RS_REDIRECT;
                end
            end
            RS_REDIRECT: begin
                if (errorM) begin
                    flush_req = 1'b1;
                    loadPc    = 1'b1;
                    nextState = RS_REDIRECT;
                end else if (redirect_ready) begin
                    nextState = RS_IDLE;
                end
            end
            default: nextState = RS_IDLE;
        endcase
    end

    assign redirect_valid = (state == RS_REDIRECT);

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with 4-bit counters so saturation is reachable.
module tb_branch_resolve;

    localparam int PC_W  = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             branchD;
    logic             pred_takeD;
    logic [PC_W-1:0]  pcD;
    logic [PC_W-1:0]  targetD;
    logic             stallE;
    logic             flushE;
    logic             stallM;
    logic             flushM;
    logic             actual_takeE;
    logic             branchM;
    logic             actual_takeM;
    logic             errorM;
    logic             flush_req;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             redirect_ready;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    int total  = 0;
    int passed = 0;

    branch_resolve #(.PC_W(PC_W), .CNT_W(CNT_W), .FALLTHRU_OFF(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .branchD        (branchD),
        .pred_takeD     (pred_takeD),
        .pcD            (pcD),
        .targetD        (targetD),
        .stallE         (stallE),
        .flushE         (flushE),
        .stallM         (stallM),
        .flushM         (flushM),
        .actual_takeE   (actual_takeE),
        .branchM        (branchM),
        .actual_takeM   (actual_takeM),
        .errorM         (errorM),
        .flush_req      (flush_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1;
        branchD = 0; pred_takeD = 0; pcD = '0; targetD = '0;
        stallE = 0; flushE = 0; stallM = 0; flushM = 0;
        actual_takeE = 0; redirect_ready = 0;
        #1 rst = 1'b0;
        #2;
        chk("rst_branchM", 32'(branchM), 0);
        chk("rst_valid", 32'(redirect_valid), 0);
        chk("rst_bcnt", 32'(branch_cnt), 0);
        chk("rst_mcnt", 32'(mispred_cnt), 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // correctly predicted taken branch
        branchD = 1; pred_takeD = 1; pcD = 32'h100; targetD = 32'h200; actual_takeE = 1;
        tick();
        branchD = 0;
        tick();
        chk("ok_branchM", 32'(branchM), 1);
        chk("ok_actualM", 32'(actual_takeM), 1);
        chk("ok_errorM", 32'(errorM), 0);
        chk("ok_flush", 32'(flush_req), 0);
        tick();
        chk("ok_bcnt", 32'(branch_cnt), 1);
        chk("ok_mcnt", 32'(mispred_cnt), 0);
        chk("ok_valid", 32'(redirect_valid), 0);

        // predicted taken, actually not taken
        branchD = 1; pred_takeD = 1; pcD = 32'h100; targetD = 32'h200; actual_takeE = 0;
        tick();
        branchD = 0;
        tick();
        chk("nt_errorM", 32'(errorM), 1);
        chk("nt_flush", 32'(flush_req), 1);
        chk("nt_valid_pre", 32'(redirect_valid), 0);
        tick();
        chk("nt_errorM_once", 32'(errorM), 0);
        chk("nt_flush_once", 32'(flush_req), 0);
        chk("nt_valid", 32'(redirect_valid), 1);
        chk("nt_pc", redirect_pc, 32'h104);
        chk("nt_bcnt", 32'(branch_cnt), 2);
        chk("nt_mcnt", 32'(mispred_cnt), 1);

        // fetch holds off for three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hs_valid_hold", 32'(redirect_valid), 1);
            chk("hs_pc_hold", redirect_pc, 32'h104);
        end
        redirect_ready = 1;
        #1;
        chk("hs_valid_at_accept", 32'(redirect_valid), 1);
        tick();
        redirect_ready = 0;
        chk("hs_valid_drop", 32'(redirect_valid), 0);

        // predicted not taken, actually taken, held in M for 4 cycles
        branchD = 1; pred_takeD = 0; pcD = 32'h140; targetD = 32'h300; actual_takeE = 1;
        tick();
        branchD = 0;
        tick();
        chk("st_errorM", 32'(errorM), 1);
        chk("st_flush", 32'(flush_req), 1);
        stallM = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("st_errorM_once", 32'(errorM), 0);
            chk("st_flush_once", 32'(flush_req), 0);
            chk("st_branchM_held", 32'(branchM), 1);
        end
        chk("st_pc", redirect_pc, 32'h300);
        chk("st_bcnt", 32'(branch_cnt), 3);
        chk("st_mcnt", 32'(mispred_cnt), 2);
        stallM = 0;
        redirect_ready = 1;
        tick();
        redirect_ready = 0;
        chk("st_valid_drop", 32'(redirect_valid), 0);

        // stream of mispredicts drives both counters to saturation
        redirect_ready = 1;
        branchD = 1; pred_takeD = 1; pcD = 32'h1c0; targetD = 32'h400; actual_takeE = 0;
        for (int i = 0; i < 19; i++) tick();
        branchD = 0;
        for (int i = 0; i < 3; i++) tick();
        chk("sat_bcnt", 32'(branch_cnt), 15);
        chk("sat_mcnt", 32'(mispred_cnt), 15);
        chk("sat_pc", redirect_pc, 32'h1c4);
        chk("sat_valid_done", 32'(redirect_valid), 0);
        redirect_ready = 0;

        // asynchronous reset while a redirect is pending
        branchD = 1; pred_takeD = 1; pcD = 32'h180; targetD = 32'h500; actual_takeE = 0;
        tick();
        branchD = 0;
        tick();
        tick();
        chk("ar_valid_pre", 32'(redirect_valid), 1);
        chk("ar_pc_pre", redirect_pc, 32'h184);
        #2 rst = 1'b0;
        #1;
        chk("ar_valid", 32'(redirect_valid), 0);
        chk("ar_bcnt", 32'(branch_cnt), 0);
        chk("ar_mcnt", 32'(mispred_cnt), 0);
        chk("ar_pc", redirect_pc, 0);
        #2 rst = 1'b1;
        tick();

        // branch flushed out of D->E never resolves
        branchD = 1; pred_takeD = 1; pcD = 32'h200; targetD = 32'h600; actual_takeE = 0;
        flushE = 1; stallE = 1;
        tick();
        branchD = 0; flushE = 0; stallE = 0;
        tick();
        chk("fe_branchM", 32'(branchM), 0);
        chk("fe_errorM", 32'(errorM), 0);
        tick();
        chk("fe_bcnt", 32'(branch_cnt), 0);
        chk("fe_mcnt", 32'(mispred_cnt), 0);
        chk("fe_valid", 32'(redirect_valid), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Downstream partner of the gshare predictor. Carries each branch's D-stage prediction and target through the E and M pipeline registers.
- Resolves the branch in M and produces the predictor's update and repair inputs: branchM, actual_takeM and errorM.
- On a mispredict, raises a one-shot pipeline flush request and holds a redirect PC to fetch under a valid/ready handshake.
- Keeps saturating branch and mispredict counters for performance reporting.

Parameters:
- PC_W, 32, PC and target width.
- CNT_W, 32, width of each performance counter.
- FALLTHRU_OFF, 4, byte offset from a branch PC to its not-taken successor.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- branchD  in  1  D-stage instruction is a conditional branch.
- pred_takeD  in  1  predictor's taken prediction for the D instruction.
- pcD  in  PC_W  PC of the D instruction.
- targetD  in  PC_W  taken target computed in D.
- stallE, flushE  in  1  hold or clear the D->E register.
- stallM, flushM  in  1  hold or clear the E->M register.
- actual_takeE  in  1  branch condition result from the E comparator.
- branchM  out  1  M-stage instruction is a branch.
- actual_takeM  out  1  resolved direction in M.
- errorM  out  1  M branch mispredicted; asserted only on its first M cycle.
- flush_req  out  1  one-cycle request to flush F/D/E.
- redirect_valid  out  1  redirect PC pending.
- redirect_pc  out  PC_W  correct next fetch PC.
- redirect_ready  in  1  fetch accepts the redirect.
- branch_cnt  out  CNT_W  resolved branches.
- mispred_cnt  out  CNT_W  mispredicted branches.

Behaviour:
- Reset (rst=0, asynchronous): all pipeline registers, counters, outputs and FSM clear to 0, state IDLE. Reset mid-redirect drops the pending redirect.
- D->E register (branch, pred, pc, target):
  - flushE clears branch/pred to 0; flushE has priority over stallE.
  - stallE holds; otherwise the register loads the D inputs.
- E->M register:
  - Same rule with flushM/stallM.
  - Captures actual_takeE together with the E-stage fields.
- first_m flag:
  - Set when a new instruction enters M.
  - Cleared after one cycle while stallM holds, so a stalled branch resolves exactly once.
- Outputs:
  - branchM and actual_takeM are the registered M fields.
  - errorM = branchM & first_m & (predM != actual_takeM).
- Resolution (when branchM & first_m):
  - branch_cnt increments.
  - If errorM, mispred_cnt also increments.
  - Both counters saturate at all-ones and never wrap.
- FSM state IDLE:
  - On errorM: flush_req=1 for that cycle (combinational with errorM).
  - redirect_pc is loaded at the clock edge: targetM if actual_takeM=1, else pcM+FALLTHRU_OFF (modulo 2^PC_W).
  - Next state REDIRECT.
- FSM state REDIRECT:
  - redirect_valid=1; redirect_pc stays stable until the transfer.
  - redirect_valid & redirect_ready completes the transfer; next state IDLE.
  - An errorM in the same cycle as the transfer reloads redirect_pc and stays in REDIRECT.
  - An errorM with no transfer overwrites redirect_pc (the newer resolution wins), reasserts flush_req and stays in REDIRECT.
- redirect_valid is 0 in IDLE. Latency from errorM to redirect_valid is 1 cycle.
- Counters change only on resolution; flushes of E/M never count.

Decomposition:
- Shared package pipe_pkg:
  - FSM state encoding RS_IDLE=1'b0, RS_REDIRECT=1'b1.
  - Typedef br_info_t {branch, pred, pc, target, actual}.
  - Constant FALLTHRU_OFF.
- Sub-module sat_counter (CNT_W, inc input, asynchronous active-low reset), instanced twice.

Test Plan:
- Correct prediction: branchD=1, pred=1, pcD=0x100, targetD=0x200, actual_takeE=1. Two cycles later: branchM=1, errorM=0, flush_req=0, branch_cnt=1, mispred_cnt=0.
- Not-taken mispredict: pred=1, actual=0, pcD=0x100. In M: errorM=1 and flush_req=1 for one cycle. Next cycle: redirect_valid=1, redirect_pc=0x104, mispred_cnt=1.
- Handshake: hold redirect_ready=0 for 3 cycles, then 1. redirect_valid and redirect_pc=0x104 stay stable, then drop after the accepting edge.
- stallM for 4 cycles on a mispredicted branch (pred=0, actual=1, targetD=0x300). errorM pulses once, counters increment once, redirect_pc=0x300.
- Saturation (CNT_W=4): resolve 17 mispredicted branches -> branch_cnt=mispred_cnt=15.
- rst=0 asserted asynchronously mid-REDIRECT -> redirect_valid=0 and counters=0 immediately, without a clock edge. flushE on a branch in D -> nothing counted, no errorM.
